// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: common widths, the default reset PC, the canonical NOP encoding and
// the {pc, inst} entry type carried through the prefetch queue.
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue holding fetched {pc, inst} entries
//
// Purpose: DEPTH-entry synchronous FIFO with a flush that empties it in one edge.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write wdata at the tail
//   pop           drop the head entry
//   flush         empty the queue; overrides push and pop
//   count         occupancy, 0..DEPTH
//   full, empty   occupancy flags
//   head          entry at the read pointer (undefined contents when empty)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the caller masks head whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign head  = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC sequencing, imem request and prefetch queue front end
//
// Purpose: holds the fetch PC, presents its word index to instruction memory,
// queues the returned instruction with its PC and hands entries to decode.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   imem_addr / imem_inst       word index out, combinational instruction back
//   redirect_valid/redirect_pc  execute-side PC change; flushes the queue
//   out_valid/out_ready         decode handshake on the queue head
//   out_inst/out_pc             head entry, forced to 0 while the queue is empty
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0]              fetch_pc;
  logic                         push;
  logic                         pop;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_full;
  logic                         fifo_empty;
  fetch_entry_t                 fifo_head;
  fetch_entry_t                 fetch_entry;

  assign pop  = out_valid & out_ready;
  // A pop frees a slot in the same edge, so a full queue still streams.
  assign push = !redirect_valid & (!fifo_full | pop);

  assign imem_addr   = fetch_pc >> 2;
  assign fetch_entry = '{pc: fetch_pc, inst: imem_inst};

  // Word alignment is enforced by masking rather than slicing so every
  // redirect bit is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC & ~32'h3;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h3;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (fetch_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign out_valid = (fifo_count != '0);
  assign out_inst  = fifo_empty ? '0 : fifo_head.inst;
  assign out_pc    = fifo_empty ? '0 : fifo_head.pc;

endmodule
